whack_game_ctrl: RTL and testbench
==================================

# whack_game_ctrl

Top-level sequencer for the whack-a-mole game. Drives the datapath's 3-bit `state` code and schedules mole appearances: it picks a hole, times how long the mole stays up, filters player hits, and advances difficulty level. It ends the game when all rounds are played or when the game timer expires. It sits between the input/rate-divider logic and the score datapath, and is the only source of `state`.

## Interface
- `UP_TICKS`, default 32: mole-up duration at level 1, in `tick` pulses; range 2..255.
- `DOWN_TICKS`, default 8: gap between moles, in ticks; range 1..255.
- `START_TICKS`, default 16: "get ready" delay before level 1, in ticks.
- `ROUNDS`, default 8: moles per level; range 1..255.
- `clk`  in  1  system clock.
- `Reset`  in  1  reset; synchronous, active-high.
- `start_key`  in  1  level input from the start key; the block detects the rising edge internally.
- `tick`  in  1  one-cycle pulse from the rate divider.
- `hit`  in  1  one-cycle pulse; player struck the currently shown hole (already position-matched upstream).
- `timer_done`  in  1  game timer expired (level).
- `state`  out  3  datapath code: 000 IDLE, 001 START, 010 LVL1, 011 LVL2, 100 LVL3, 101 LVL4, 110 DONE.
- `mole_pos`  out  4  hole index 0..15 of the current mole.
- `mole_visible`  out  1  mole currently up.
- `score_inc`  out  1  one-cycle pulse per accepted hit.
- `level`  out  2  0..3, equals `state`−2 in the LVL states, otherwise 0.
- `game_over`  out  1  high in DONE.

## Operation
- **IDLE:** all outputs low or zero. A `start_key` rising edge moves the block to START and clears the tick counter.
- **START:** counts `START_TICKS` ticks, then moves to LVL1 in the MOLE_DOWN phase with `round_cnt`=0.
- **LVL1–LVL4** have two sub-phases.
  - MOLE_DOWN: counts `DOWN_TICKS` ticks. At the end it loads a new `mole_pos`, sets `mole_visible`, and enters MOLE_UP.
  - MOLE_UP: counts `up_len` = max(1, `UP_TICKS` >> `level`) ticks.
    - On expiry: clear visible, increment `round_cnt`, go to MOLE_DOWN.
    - On an accepted `hit`: same actions, one cycle early.
- **Hit acceptance:** `hit` is accepted only when `mole_visible`=1, and at most once per mole. Hits in MOLE_DOWN, START, IDLE or DONE are ignored.
- **Level advance:** when `round_cnt` reaches `ROUNDS` at the end of MOLE_UP, go to the next LVL state and reset `round_cnt`. After LVL4 the next state is DONE.
- **timer_done:** high in any LVL state forces DONE on the next edge. It has priority over a same-cycle `hit`; that hit is not scored. `timer_done` is ignored in IDLE and START.
- **DONE:** holds until a `start_key` rising edge, then goes to START (new game).
- **Position:** an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is seeded 8'hA5 on reset and steps every clock. The new `mole_pos` is `lfsr[3:0]`. If that equals the previous `mole_pos`, use (`lfsr[3:0]`+1) mod 16 instead, so the same hole never appears twice in a row.
- **Counters:** the tick counter is 8 bits and compares against the terminal value minus 1. It increments only on `tick`.

## Timing
- All outputs are registered.
- **Reset:** applies on the edge where `Reset`=1 and has priority over everything.
  - Outputs after reset: `state`=000, `mole_pos`=0, `mole_visible`=0, `score_inc`=0, `level`=0, `game_over`=0.
  - LFSR=8'hA5 and all counters=0.
  - Reset mid-game abandons the game immediately.
- **Hit latency:** `hit` sampled at edge N with `mole_visible`=1 gives `score_inc`=1 and `mole_visible`=0 for exactly the cycle after N.
- **Start latency:** a `start_key` rising edge sampled at edge N gives `state`=001 after N.
- **timer_done latency:** `timer_done` sampled at edge N in a LVL state gives `state`=110 and `mole_visible`=0 after N.
- **Phase ends:** a phase ends on the edge that samples the terminal `tick`.
- **Simultaneous events:** when the MOLE_UP expiry tick and an accepted `hit` coincide, the hit is scored and the mole ends once (`round_cnt` +1, not +2).

## Structure
- Shared package `whack_pkg` holds:
  - state encodings `ST_IDLE`..`ST_DONE` (also used by the datapath);
  - `LFSR_SEED`;
  - the LFSR tap mask.
- Sub-module `mole_lfsr` contains the 8-bit LFSR plus the no-repeat adjust.
  - Ports: `clk`, `Reset`, `load`, `prev_pos`[3:0], `pos`[3:0].
- The top level holds the main FSM, the MOLE_UP/MOLE_DOWN sub-phase, the tick/round counters, and the start-key edge detector.

## Test plan
- **Reset then start:** `Reset` pulse, then `start_key` rise, defaults → `state` 000→001, then 001→010 after 16 ticks; `mole_visible` rises after 8 more ticks.
- **Hit timing:** `hit` while visible → `score_inc` is a single one-cycle pulse, next mole appears 8 ticks later. A second `hit` on the same mole, or a `hit` during MOLE_DOWN → no pulse.
- **Level progression:** no hits, `ROUNDS`=2 → two moles per level; LVL1 up-time 32 ticks, LVL2 16, LVL3 8, LVL4 4; after 8 moles `state`=110 and `game_over`=1.
- **Timer interrupt:** `timer_done` and `hit` in the same cycle during LVL2 → `state`=110 next cycle, no `score_inc`, `mole_visible`=0.
- **Position check:** `mole_pos` stays in 0..15 and never repeats back-to-back over 200 moles; the first sequence after reset matches the seed 8'hA5 model.
- **Mid-game reset and restart:** `Reset` during LVL3 MOLE_UP → all outputs at reset values next cycle. `start_key` rise in DONE → `state`=001.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole controller and the score datapath.
package whack_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned POS_W   = 4;
   localparam int unsigned LVL_W   = 2;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned LFSR_W  = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_LVL1  = 3'd2,
      ST_LVL2  = 3'd3,
      ST_LVL3  = 3'd4,
      ST_LVL4  = 3'd5,
      ST_DONE  = 3'd6
   } state_e;

   typedef enum logic {
      PH_DOWN = 1'b0,
      PH_UP   = 1'b1
   } phase_e;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
   // x^8+x^6+x^5+x^4+1 on a left-shifting register: taps at bits 7,5,4,3
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

   function automatic logic [POS_W-1:0] no_repeat(input logic [POS_W-1:0] cand,
                                                  input logic [POS_W-1:0] prev);
      return (cand == prev) ? POS_W'(cand + 4'd1) : cand;
   endfunction

   function automatic logic [CNT_W-1:0] up_len(input logic [CNT_W-1:0] base,
                                               input logic [LVL_W-1:0] lvl);
      logic [CNT_W-1:0] s;
      s = base >> lvl;
      return (s == '0) ? CNT_W'(1) : s;
   endfunction

   function automatic state_e next_level(input state_e s);
      return (s == ST_LVL4) ? ST_DONE : state_e'(STATE_W'(s) + 3'd1);
   endfunction

   function automatic logic [LVL_W-1:0] level_of(input state_e s);
      logic [LVL_W-1:0] l;
      l = '0;
      if (s == ST_LVL1 || s == ST_LVL2 || s == ST_LVL3 || s == ST_LVL4)
         l = LVL_W'(STATE_W'(s) - STATE_W'(ST_LVL1));
      return l;
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit LFSR; on load it latches a hole index that differs from prev_pos.
module mole_lfsr
   import whack_pkg::*;
(
   input  logic             clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [POS_W-1:0] prev_pos,
   output logic [POS_W-1:0] pos
);

   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge clk) begin
      if (Reset) begin
         lfsr <= LFSR_SEED;
         pos  <= '0;
      end else begin
         lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
         if (load)
            pos <= no_repeat(lfsr[POS_W-1:0], prev_pos);
      end
   end

endmodule

// File: rtl/whack_game_ctrl.sv
// Game sequencer: drives the datapath state code, schedules moles, filters hits, advances levels.
module whack_game_ctrl
   import whack_pkg::*;
#(
   parameter int unsigned UP_TICKS    = 32,
   parameter int unsigned DOWN_TICKS  = 8,
   parameter int unsigned START_TICKS = 16,
   parameter int unsigned ROUNDS      = 8
)(
   input  logic               clk,
   input  logic               Reset,
   input  logic               start_key,
   input  logic               tick,
   input  logic               hit,
   input  logic               timer_done,
   output logic [STATE_W-1:0] state,
   output logic [POS_W-1:0]   mole_pos,
   output logic               mole_visible,
   output logic               score_inc,
   output logic [LVL_W-1:0]   level,
   output logic               game_over
);

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TICKS - 1);
   localparam logic [CNT_W-1:0] DOWN_LAST  = CNT_W'(DOWN_TICKS - 1);
   localparam logic [CNT_W-1:0] UP_BASE    = CNT_W'(UP_TICKS);
   localparam logic [CNT_W-1:0] ROUNDS_L   = CNT_W'(ROUNDS);

   state_e           st_q, st_n;
   phase_e           ph_q, ph_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [CNT_W-1:0] round_q, round_n;
   logic             key_q;
   logic             vis_q, vis_n;
   logic             score_q, score_n;
   logic [LVL_W-1:0] level_q, level_n;
   logic             over_q, over_n;

   logic             rise_c;
   logic             hit_ok_c;
   logic             up_end_c;
   logic             load_c;
   logic [CNT_W-1:0] up_last_c;
   logic [CNT_W-1:0] cnt_inc_c;
   logic [CNT_W-1:0] round_inc_c;

   assign rise_c      = start_key & ~key_q;
   assign hit_ok_c    = hit & vis_q;
   assign up_last_c   = CNT_W'(up_len(UP_BASE, level_q) - 8'd1);
   assign up_end_c    = tick & (cnt_q == up_last_c);
   assign cnt_inc_c   = CNT_W'(cnt_q + 8'd1);
   assign round_inc_c = CNT_W'(round_q + 8'd1);

   always_ff @(posedge clk) begin
      if (Reset) begin
         st_q    <= ST_IDLE;
         ph_q    <= PH_DOWN;
         cnt_q   <= '0;
         round_q <= '0;
         key_q   <= 1'b0;
         vis_q   <= 1'b0;
         score_q <= 1'b0;
         level_q <= '0;
         over_q  <= 1'b0;
      end else begin
         st_q    <= st_n;
         ph_q    <= ph_n;
         cnt_q   <= cnt_n;
         round_q <= round_n;
         key_q   <= start_key;
         vis_q   <= vis_n;
         score_q <= score_n;
         level_q <= level_n;
         over_q  <= over_n;
      end
   end

   always_comb begin
      st_n    = st_q;
      ph_n    = ph_q;
      cnt_n   = cnt_q;
      round_n = round_q;
      vis_n   = vis_q;
      score_n = 1'b0;
      load_c  = 1'b0;

      case (st_q)
         ST_IDLE, ST_DONE: begin
            vis_n = 1'b0;
            ph_n  = PH_DOWN;
            if (rise_c) begin
               st_n  = ST_START;
               cnt_n = '0;
            end
         end

         ST_START: begin
            if (tick) begin
               if (cnt_q == START_LAST) begin
                  st_n    = ST_LVL1;
                  ph_n    = PH_DOWN;
                  cnt_n   = '0;
                  round_n = '0;
               end else begin
                  cnt_n = cnt_inc_c;
               end
            end
         end

         ST_LVL1, ST_LVL2, ST_LVL3, ST_LVL4: begin
            // timer expiry wins over everything, including a same-cycle hit
            if (timer_done) begin
               st_n  = ST_DONE;
               vis_n = 1'b0;
               ph_n  = PH_DOWN;
               cnt_n = '0;
            end else if (ph_q == PH_DOWN) begin
               if (tick) begin
                  if (cnt_q == DOWN_LAST) begin
                     load_c = 1'b1;
                     vis_n  = 1'b1;
                     ph_n   = PH_UP;
                     cnt_n  = '0;
                  end else begin
                     cnt_n = cnt_inc_c;
                  end
               end
            end else begin
               // a hit and the expiry tick together still end the mole only once
               if (hit_ok_c || up_end_c) begin
                  score_n = hit_ok_c;
                  vis_n   = 1'b0;
                  ph_n    = PH_DOWN;
                  cnt_n   = '0;
                  if (round_inc_c == ROUNDS_L) begin
                     round_n = '0;
                     st_n    = next_level(st_q);
                  end else begin
                     round_n = round_inc_c;
                  end
               end else if (tick) begin
                  cnt_n = cnt_inc_c;
               end
            end
         end

         default: begin
            st_n  = ST_IDLE;
            vis_n = 1'b0;
            ph_n  = PH_DOWN;
            cnt_n = '0;
         end
      endcase

      level_n = level_of(st_n);
      over_n  = (st_n == ST_DONE);
   end

   mole_lfsr u_lfsr (
      .clk      (clk),
      .Reset    (Reset),
      .load     (load_c),
      .prev_pos (mole_pos),
      .pos      (mole_pos)
   );

   assign state        = st_q;
   assign mole_visible = vis_q;
   assign score_inc    = score_q;
   assign level        = level_q;
   assign game_over    = over_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: directed timing scenarios plus a long randomized run
// compared cycle by cycle against a countdown-based game model.
module tb_whack_game_ctrl;

   localparam int UPT = 32;
   localparam int DNT = 8;
   localparam int STT = 16;
   localparam int RND = 2;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       start_key = 1'b0;
   logic       tick = 1'b0;
   logic       hit = 1'b0;
   logic       timer_done = 1'b0;
   logic [2:0] state;
   logic [3:0] mole_pos;
   logic       mole_visible;
   logic       score_inc;
   logic [1:0] level;
   logic       game_over;

   int total = 0;
   int bad = 0;

   whack_game_ctrl #(
      .UP_TICKS    (UPT),
      .DOWN_TICKS  (DNT),
      .START_TICKS (STT),
      .ROUNDS      (RND)
   ) dut (
      .clk          (clk),
      .Reset        (Reset),
      .start_key    (start_key),
      .tick         (tick),
      .hit          (hit),
      .timer_done   (timer_done),
      .state        (state),
      .mole_pos     (mole_pos),
      .mole_visible (mole_visible),
      .score_inc    (score_inc),
      .level        (level),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   // game model: mode 0 idle, 1 get-ready, 2..5 levels, 6 over; m_left counts ticks remaining
   int         m_mode = 0;
   bit         m_up = 0;
   int         m_left = 0;
   int         m_moles = 0;
   logic [3:0] m_pos = '0;
   bit         m_vis = 0;
   bit         m_score = 0;
   logic [7:0] m_lfsr = 8'hA5;
   bit         m_key = 0;
   logic [7:0] m_cur;
   logic [3:0] m_cand;
   bit         m_rise;
   bit         m_end;

   function automatic int up_ticks_for(input int lvl);
      int t;
      t = UPT / (1 << lvl);
      return (t < 1) ? 1 : t;
   endfunction

   always @(posedge clk) begin
      if (Reset) begin
         m_mode = 0; m_up = 0; m_left = 0; m_moles = 0;
         m_pos = '0; m_vis = 0; m_score = 0; m_lfsr = 8'hA5; m_key = 0;
      end else begin
         m_rise = start_key && !m_key;
         m_key  = start_key;
         m_cur  = m_lfsr;
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         m_score = 0;
         if (m_mode == 0 || m_mode == 6) begin
            if (m_rise) begin
               m_mode = 1; m_left = STT;
            end
         end else if (m_mode == 1) begin
            if (tick) begin
               m_left--;
               if (m_left == 0) begin
                  m_mode = 2; m_up = 0; m_left = DNT; m_moles = RND;
               end
            end
         end else if (timer_done) begin
            m_mode = 6; m_vis = 0; m_up = 0;
         end else if (!m_up) begin
            if (tick) begin
               m_left--;
               if (m_left == 0) begin
                  m_cand = m_cur[3:0];
                  if (m_cand == m_pos) m_cand = m_cand + 4'd1;
                  m_pos = m_cand; m_vis = 1; m_up = 1;
                  m_left = up_ticks_for(m_mode - 2);
               end
            end
         end else begin
            m_end = 0;
            if (hit && m_vis) begin
               m_score = 1; m_end = 1;
            end
            if (tick) begin
               m_left--;
               if (m_left == 0) m_end = 1;
            end
            if (m_end) begin
               m_vis = 0; m_up = 0; m_left = DNT;
               m_moles--;
               if (m_moles == 0) begin
                  m_mode++; m_moles = RND;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   logic [3:0] last_pos = '0;
   bit         vis_prev = 0;
   int         moles = 0;
   int         n;

   // advance one clock and compare every output with the model
   task automatic cyc();
      logic [11:0] exp_v;
      logic [1:0]  exp_l;
      @(negedge clk);
      exp_l = (m_mode >= 2 && m_mode <= 5) ? 2'(m_mode - 2) : 2'd0;
      exp_v = {3'(m_mode), m_pos, m_vis, m_score, exp_l, (m_mode == 6)};
      check("outs", {20'd0, state, mole_pos, mole_visible, score_inc, level, game_over},
            {20'd0, exp_v});
      if (Reset) begin
         last_pos = '0;
         vis_prev = 0;
      end else begin
         if (mole_visible && !vis_prev) begin
            moles++;
            check("norep", {31'd0, mole_pos == last_pos}, 32'd0);
            last_pos = mole_pos;
         end
         vis_prev = mole_visible;
      end
   endtask

   task automatic count_vis(input logic want, output int cnt);
      cnt = 0;
      while (mole_visible == want && cnt < 2000) begin
         cyc();
         cnt++;
      end
   endtask

   task automatic wait_state_vis(input logic [2:0] st, output int cnt);
      cnt = 0;
      while (!(state == st && mole_visible) && cnt < 5000) begin
         cyc();
         cnt++;
      end
   endtask

   initial begin
      cyc();
      Reset = 1'b0;
      check("rst_outs", {20'd0, state, mole_pos, mole_visible, score_inc, level, game_over}, 32'd0);

      // level progression with a tick every cycle and no hits
      tick = 1'b1;
      start_key = 1'b1;
      cyc();
      start_key = 1'b0;
      check("start_lat", 32'(state), 32'd1);
      n = 0;
      while (state == 3'd1 && n < 200) begin cyc(); n++; end
      check("start_len", n, STT);
      check("lvl1_state", 32'(state), 32'd2);
      count_vis(1'b0, n);
      check("first_down", n, DNT);
      for (int i = 0; i < 4 * RND; i++) begin
         check("mole_level", 32'(level), 32'(i / RND));
         count_vis(1'b1, n);
         check("up_len", n, UPT >> (i / RND));
         if (i < 4 * RND - 1) begin
            count_vis(1'b0, n);
            check("down_len", n, DNT);
         end
      end
      check("done_state", 32'(state), 32'd6);
      check("done_over", 32'(game_over), 32'd1);

      // restart from DONE, then hit timing
      start_key = 1'b1;
      cyc();
      start_key = 1'b0;
      check("restart", 32'(state), 32'd1);
      count_vis(1'b0, n);
      check("restart_vis", 32'(mole_visible), 32'd1);
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      check("hit_score", 32'(score_inc), 32'd1);
      check("hit_vis", 32'(mole_visible), 32'd0);
      n = 0;
      cyc(); n++;
      check("hit_pulse", 32'(score_inc), 32'd0);
      hit = 1'b1;
      cyc(); n++;
      hit = 1'b0;
      check("hit_down", 32'(score_inc), 32'd0);
      while (!mole_visible && n < 2000) begin cyc(); n++; end
      check("hit_gap", n, DNT);

      // timer expiry and hit together in LVL2
      wait_state_vis(3'd3, n);
      check("reach_lvl2", 32'(n < 5000), 32'd1);
      timer_done = 1'b1;
      hit = 1'b1;
      cyc();
      timer_done = 1'b0;
      hit = 1'b0;
      check("tmr_state", 32'(state), 32'd6);
      check("tmr_score", 32'(score_inc), 32'd0);
      check("tmr_vis", 32'(mole_visible), 32'd0);

      // reset during LVL3 with a mole up
      start_key = 1'b1;
      cyc();
      start_key = 1'b0;
      wait_state_vis(3'd4, n);
      check("reach_lvl3", 32'(n < 5000), 32'd1);
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
      check("mid_rst", {20'd0, state, mole_pos, mole_visible, score_inc, level, game_over}, 32'd0);

      // randomized play
      for (int i = 0; i < 20000; i++) begin
         tick       = 1'($urandom_range(0, 1));
         hit        = ($urandom_range(0, 3) == 0);
         timer_done = ($urandom_range(0, 2999) == 0);
         if ($urandom_range(0, 39) == 0) start_key = ~start_key;
         Reset      = ($urandom_range(0, 3999) == 0);
         cyc();
      end
      Reset = 1'b0;
      check("mole_count", 32'(moles >= 200), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
